fp_mul_arbiter: RTL and testbench

Shares one FP32 multiplier (combinational or pipelined, fixed latency) between two requesters. Each requester has a valid/ready issue port and its own response valid/ready. Selection is round-robin. The block registers the operands that drive the multiplier, counts the multiplier latency, captures the result and exception flags, and holds them until the owning requester accepts them. Only one operation is in flight at a time. The block sits between the two issue units and the fp_mul datapath.

---
 rtl/fp_mul_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_fp_mul_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin sharing of one fixed-latency FP32 multiplier
// between two requesters. One operation is in flight at a time. The operands
// are registered towards the multiplier, the result is captured after MUL_LAT
// cycles, and it is held until the owning requester accepts it.
module fp_mul_arbiter #(
  parameter int MUL_LAT = 1,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [31:0]      req_X0,
  input  logic [31:0]      req_Y0,
  input  logic [31:0]      req_X1,
  input  logic [31:0]      req_Y1,
  input  logic [2:0]       req_rmode0,
  input  logic [2:0]       req_rmode1,
  input  logic [TAG_W-1:0] req_tag0,
  input  logic [TAG_W-1:0] req_tag1,
  output logic [31:0]      mul_X,
  output logic [31:0]      mul_Y,
  output logic [2:0]       mul_rmode,
  input  logic [31:0]      mul_Z,
  input  logic             mul_ovrf,
  input  logic             mul_udrf,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [31:0]      rsp_Z,
  output logic             rsp_ovrf,
  output logic             rsp_udrf,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Quiet NaN returned in place of the product for an illegal rounding mode.
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             rr_q;
  logic             owner_q;
  logic             err_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      mul_x_q, mul_y_q;
  logic [2:0]       mul_rmode_q;
  logic [31:0]      rsp_z_q;
  logic             rsp_ovrf_q, rsp_udrf_q;

  logic             grant;
  logic             accept;
  logic             capture;
  logic             complete;
  logic [31:0]      gnt_x, gnt_y;
  logic [2:0]       gnt_rmode;
  logic [TAG_W-1:0] gnt_tag;

  // Arbitration: round-robin pointer breaks ties, a lone request always wins.
  always_comb begin
    req_ready = 2'b00;
    grant     = rr_q;
    if (state_q == S_IDLE) begin
      case (req_valid)
        2'b11: begin
          grant            = rr_q;
          req_ready[rr_q]  = 1'b1;
        end
        2'b01: begin
          grant        = 1'b0;
          req_ready[0] = 1'b1;
        end
        2'b10: begin
          grant        = 1'b1;
          req_ready[1] = 1'b1;
        end
        default: begin
          grant     = rr_q;
          req_ready = 2'b00;
        end
      endcase
    end
  end

  assign accept    = |req_ready;
  assign capture   = (state_q == S_BUSY) && (cnt_q == 4'd1);
  assign complete  = (state_q == S_DONE) && rsp_ready[owner_q];

  assign gnt_x     = grant ? req_X1     : req_X0;
  assign gnt_y     = grant ? req_Y1     : req_Y0;
  assign gnt_rmode = grant ? req_rmode1 : req_rmode0;
  assign gnt_tag   = grant ? req_tag1   : req_tag0;

  // Next-state and latency counter: counter is loaded on accept and walks
  // down to 1, the edge at which the multiplier output is valid.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_BUSY;
          cnt_d   = 4'(MUL_LAT);
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_DONE;
      end
      S_DONE: begin
        if (rsp_ready[owner_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state: FSM, counter, round-robin pointer and per-operation
  // bookkeeping (owner, tag, illegal-mode flag) latched at accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      err_q   <= 1'b0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (complete) rr_q <= ~owner_q;
      if (accept) begin
        owner_q <= grant;
        err_q   <= (gnt_rmode > 3'd4);
        tag_q   <= gnt_tag;
      end
    end
  end

  // Operand registers feeding the multiplier; they only move on accept so the
  // multiplier sees stable inputs for the whole operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_x_q     <= 32'd0;
      mul_y_q     <= 32'd0;
      mul_rmode_q <= 3'd0;
    end else if (accept) begin
      mul_x_q     <= gnt_x;
      mul_y_q     <= gnt_y;
      mul_rmode_q <= gnt_rmode;
    end
  end

  // Result capture on the final latency edge; an illegal rounding mode
  // replaces the multiplier output with a quiet NaN and clears the flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_z_q    <= 32'd0;
      rsp_ovrf_q <= 1'b0;
      rsp_udrf_q <= 1'b0;
    end else if (capture) begin
      if (err_q) begin
        rsp_z_q    <= QNAN;
        rsp_ovrf_q <= 1'b0;
        rsp_udrf_q <= 1'b0;
      end else begin
        rsp_z_q    <= mul_Z;
        rsp_ovrf_q <= mul_ovrf;
        rsp_udrf_q <= mul_udrf;
      end
    end
  end

  assign mul_X     = mul_x_q;
  assign mul_Y     = mul_y_q;
  assign mul_rmode = mul_rmode_q;
  assign rsp_valid = (state_q == S_DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_Z     = rsp_z_q;
  assign rsp_ovrf  = rsp_ovrf_q;
  assign rsp_udrf  = rsp_udrf_q;
  assign rsp_err   = err_q;
  assign rsp_tag   = tag_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Testbench for fp_mul_arbiter: directed and randomized operations checked
// against a transaction-level model of arbitration, latency and capture.
module tb_fp_mul_arbiter;

  localparam int LAT   = 3;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [31:0]      req_X0, req_Y0, req_X1, req_Y1;
  logic [2:0]       req_rmode0, req_rmode1;
  logic [TAG_W-1:0] req_tag0, req_tag1;
  logic [31:0]      mul_X, mul_Y;
  logic [2:0]       mul_rmode;
  logic [31:0]      mul_Z;
  logic             mul_ovrf, mul_udrf;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [31:0]      rsp_Z;
  logic             rsp_ovrf, rsp_udrf, rsp_err;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;

  logic [31:0]      x [2];
  logic [31:0]      y [2];
  logic [2:0]       rm [2];
  logic [TAG_W-1:0] tg [2];

  assign req_X0 = x[0];  assign req_Y0 = y[0];
  assign req_X1 = x[1];  assign req_Y1 = y[1];
  assign req_rmode0 = rm[0];  assign req_rmode1 = rm[1];
  assign req_tag0 = tg[0];    assign req_tag1 = tg[1];

  int checks = 0;
  int errors = 0;
  int rr_m   = 0;   // model of whose turn it is on a tie

  always #5 clk = ~clk;

  fp_mul_arbiter #(.MUL_LAT(LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_X0(req_X0), .req_Y0(req_Y0), .req_X1(req_X1), .req_Y1(req_Y1),
    .req_rmode0(req_rmode0), .req_rmode1(req_rmode1),
    .req_tag0(req_tag0), .req_tag1(req_tag1),
    .mul_X(mul_X), .mul_Y(mul_Y), .mul_rmode(mul_rmode),
    .mul_Z(mul_Z), .mul_ovrf(mul_ovrf), .mul_udrf(mul_udrf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_Z(rsp_Z), .rsp_ovrf(rsp_ovrf), .rsp_udrf(rsp_udrf),
    .rsp_err(rsp_err), .rsp_tag(rsp_tag), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic rand_payload(input int max_rm);
    for (int k = 0; k < 2; k++) begin
      x[k]  = $urandom;
      y[k]  = $urandom;
      rm[k] = 3'($urandom_range(0, max_rm));
      tg[k] = TAG_W'($urandom);
    end
  endtask

  // One complete transaction: request, latency, optional backpressure, release.
  task automatic do_op(input logic [1:0] vmask, input int bp, input logic [31:0] zval,
                       input logic ov, input logic ud);
    int g;
    logic        e_err;
    logic [31:0] e_z;
    logic        e_ov, e_ud;
    g = (vmask == 2'b11) ? rr_m : (vmask[1] ? 1 : 0);
    e_err = (rm[g] > 3'd4);
    e_z   = e_err ? 32'h7FC0_0000 : zval;
    e_ov  = e_err ? 1'b0 : ov;
    e_ud  = e_err ? 1'b0 : ud;
    rsp_ready = 2'b00;
    req_valid = vmask;
    #1;
    check("grant", 32'(req_ready), 32'(1 << g));
    check("idle_busy", 32'(busy), 32'd0);
    @(posedge clk);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      mul_Z    = (k == LAT) ? zval : $urandom;
      mul_ovrf = (k == LAT) ? ov : 1'($urandom);
      mul_udrf = (k == LAT) ? ud : 1'($urandom);
      #1;
      check("lat_rsp_valid", 32'(rsp_valid), 32'd0);
      check("lat_req_ready", 32'(req_ready), 32'd0);
      check("lat_busy", 32'(busy), 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    mul_Z = $urandom; mul_ovrf = 1'($urandom); mul_udrf = 1'($urandom);
    #1;
    check("rsp_valid", 32'(rsp_valid), 32'(1 << g));
    check("rsp_Z", rsp_Z, e_z);
    check("rsp_ovrf", 32'(rsp_ovrf), 32'(e_ov));
    check("rsp_udrf", 32'(rsp_udrf), 32'(e_ud));
    check("rsp_err", 32'(rsp_err), 32'(e_err));
    check("rsp_tag", 32'(rsp_tag), 32'(tg[g]));
    check("mul_X", mul_X, x[g]);
    check("mul_Y", mul_Y, y[g]);
    check("mul_rmode", 32'(mul_rmode), 32'(rm[g]));
    for (int k = 0; k < bp; k++) begin
      rsp_ready = 2'(1 << (1 - g));   // non-owner ready must be ignored
      @(posedge clk);
      @(negedge clk);
      mul_Z = $urandom;
      #1;
      check("bp_rsp_valid", 32'(rsp_valid), 32'(1 << g));
      check("bp_rsp_Z", rsp_Z, e_z);
      check("bp_rsp_tag", 32'(rsp_tag), 32'(tg[g]));
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
    end
    rsp_ready = 2'(1 << g);
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 2'b00;
    req_valid = 2'b00;
    #1;
    check("done_busy", 32'(busy), 32'd0);
    check("done_rsp_valid", 32'(rsp_valid), 32'd0);
    rr_m = 1 - g;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    mul_Z = 32'h1234_5678; mul_ovrf = 1'b1; mul_udrf = 1'b1;
    rand_payload(4);
    repeat (2) @(negedge clk);
    check("rst_mul_X", mul_X, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // No request: stays idle.
    repeat (3) begin
      @(negedge clk);
      check("noreq_ready", 32'(req_ready), 32'd0);
      check("noreq_busy", 32'(busy), 32'd0);
    end

    // 3.0 * 3.0 = 9.0 from requester 0.
    x[0] = 32'h4040_0000; y[0] = 32'h4040_0000; rm[0] = 3'd1; tg[0] = 4'd5;
    do_op(2'b01, 0, 32'h4110_0000, 1'b0, 1'b0);

    // Both requesting continuously: grants alternate.
    for (int i = 0; i < 4; i++) begin
      rand_payload(4);
      do_op(2'b11, 0, $urandom, 1'($urandom), 1'($urandom));
    end

    // Ten cycles of backpressure.
    rand_payload(4);
    do_op(2'b10, 10, $urandom, 1'b1, 1'b0);

    // Illegal rounding mode.
    x[1] = 32'h3F80_0000; y[1] = 32'h3F80_0000; rm[1] = 3'd6; tg[1] = 4'd9;
    do_op(2'b10, 0, 32'h3F80_0000, 1'b1, 1'b1);

    // Random mix of request patterns, modes and backpressure.
    for (int i = 0; i < 20; i++) begin
      rand_payload(7);
      do_op(2'($urandom_range(1, 3)), int'($urandom_range(0, 3)),
            $urandom, 1'($urandom), 1'($urandom));
    end

    // Make the pointer favour requester 1, then reset in the middle of BUSY.
    rand_payload(4);
    do_op(2'b01, 0, $urandom, 1'b0, 1'b0);
    rand_payload(4);
    req_valid = 2'b11;
    #1;
    check("pre_rst_grant", 32'(req_ready), 32'd2);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    req_valid = 2'b00;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_mul_X", mul_X, 32'd0);
    check("mid_rst_mul_Y", mul_Y, 32'd0);
    check("mid_rst_rmode", 32'(mul_rmode), 32'd0);
    check("mid_rst_rsp_tag", 32'(rsp_tag), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rr_m = 0;
    repeat (LAT + 3) begin
      @(negedge clk);
      check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
    end
    rand_payload(4);
    do_op(2'b11, 0, $urandom, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
